fx68k_mul_seq: RTL and testbench

- Iterative 16x16 -> 32 multiplier for MULU/MULS.
- Sits beside the ALU datapath, directly upstream of it: it consumes the same source operands and feeds its 32-bit product back into the ALU's alue/aluOut path, together with an N/Z/V/C flag set for CCR update.
- Advances one step per phase-enable strobe, so it stays locked to the T-state timing of the core.

---
 rtl/fx68k_mul_seq.sv | 186 ++++++++++++++++++
 tb/tb_fx68k_mul_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fx68k_mul_seq.sv
// Iterative WIDTHxWIDTH -> 2*WIDTH multiplier for MULU/MULS, one step per en strobe.
// Optional data-dependent timing pad enabled by defining FX68K_MUL_TIMING_EN.
module fx68k_mul_seq #(
  parameter int WIDTH = 16,
  parameter int STEPS = WIDTH
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               en,
  input  logic               start,
  input  logic               isSigned,
  input  logic               abort,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         ccrOut
);

  localparam int CW = $clog2(STEPS + 1);

  if (STEPS != WIDTH) begin : g_cfg_err
    $error("fx68k_mul_seq: STEPS must equal WIDTH");
  end

`ifdef FX68K_MUL_TIMING_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_PAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand_q;
  logic               signed_q;
  logic [WIDTH:0]     hi;        // one guard bit so Booth add/sub never overflows
  logic [WIDTH-1:0]   lo;        // multiplier bits shift out as product bits shift in
  logic               qm1;
  logic [CW-1:0]      cnt;
  logic               load, step, wr_res;
  logic [WIDTH:0]     ext, sum, hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic               op_add, op_sub;
  logic [2*WIDTH-1:0] res;

`ifdef FX68K_MUL_TIMING_EN
  logic [CW-1:0] pad_left;
  logic          pad_dec;

  // MULU pads by set bits, MULS by bit-pair transitions of {mplier,0}.
  function automatic logic [CW-1:0] pad_count(input logic sgn, input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] bits;
    logic [CW-1:0]    n;
    bits = sgn ? (m ^ {m[WIDTH-2:0], 1'b0}) : m;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(bits[i]);
    return n;
  endfunction
`endif

  // Radix-2 Booth for MULS, plain shift-add for MULU; both retire one bit per step.
  always_comb begin
    ext    = signed_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    op_add = signed_q ? ({lo[0], qm1} == 2'b01) : lo[0];
    op_sub = signed_q & ({lo[0], qm1} == 2'b10);
    if (op_sub)      sum = hi - ext;
    else if (op_add) sum = hi + ext;
    else             sum = hi;
    hi_nxt = {signed_q & sum[WIDTH], sum[WIDTH:1]};
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
  end

  always_comb begin
    res = {hi_nxt[WIDTH-1:0], lo_nxt};
`ifdef FX68K_MUL_TIMING_EN
    if (state == S_PAD) res = {hi[WIDTH-1:0], lo};
`endif
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    wr_res    = 1'b0;
`ifdef FX68K_MUL_TIMING_EN
    pad_dec   = 1'b0;
`endif
    if (en) begin
      if (abort) begin
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state_nxt = S_RUN;
              load      = 1'b1;
            end
          end
          S_RUN: begin
            step = 1'b1;
            if (cnt == CW'(STEPS - 1)) begin
`ifdef FX68K_MUL_TIMING_EN
              if (pad_left != '0) begin
                state_nxt = S_PAD;
              end else begin
                state_nxt = S_DONE;
                wr_res    = 1'b1;
              end
`else
              state_nxt = S_DONE;
              wr_res    = 1'b1;
`endif
            end
          end
`ifdef FX68K_MUL_TIMING_EN
          S_PAD: begin
            pad_dec = 1'b1;
            if (pad_left == CW'(1)) begin
              state_nxt = S_DONE;
              wr_res    = 1'b1;
            end
          end
`endif
          S_DONE:  state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy = (state == S_RUN);
`ifdef FX68K_MUL_TIMING_EN
    busy = busy | (state == S_PAD);
`endif
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      mcand_q  <= '0;
      signed_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      qm1      <= 1'b0;
      cnt      <= '0;
      product  <= '0;
      ccrOut   <= '0;
`ifdef FX68K_MUL_TIMING_EN
      pad_left <= '0;
`endif
    end else begin
      if (load) begin
        mcand_q  <= mcand;
        signed_q <= isSigned;
        hi       <= '0;
        lo       <= mplier;
        qm1      <= 1'b0;
        cnt      <= '0;
`ifdef FX68K_MUL_TIMING_EN
        pad_left <= pad_count(isSigned, mplier);
`endif
      end
      if (step) begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        qm1 <= lo[0];
        cnt <= cnt + CW'(1);
      end
`ifdef FX68K_MUL_TIMING_EN
      if (pad_dec) pad_left <= pad_left - CW'(1);
`endif
      // Flags and product only move on the edge that enters DONE.
      if (wr_res) begin
        product <= res;
        ccrOut  <= {res[2*WIDTH-1], (res == '0), 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_fx68k_mul_seq.sv
// Self-checking bench for fx68k_mul_seq: directed corner cases plus random operands
// against an arithmetic reference model; pad expectations follow FX68K_MUL_TIMING_EN.
module tb_fx68k_mul_seq;

  logic        clk = 1'b0;
  logic        nReset, en, start, isSigned, abort;
  logic [15:0] mcand, mplier;
  logic        busy, done;
  logic [31:0] product;
  logic [3:0]  ccrOut;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] last_prod = '0;
  logic [3:0]  last_ccr  = '0;

  fx68k_mul_seq #(.WIDTH(16), .STEPS(16)) dut (
    .clk(clk), .nReset(nReset), .en(en), .start(start), .isSigned(isSigned),
    .abort(abort), .mcand(mcand), .mplier(mplier), .busy(busy), .done(done),
    .product(product), .ccrOut(ccrOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    longint x, y, p;
    if (sgn) begin x = $signed(a); y = $signed(b); end
    else     begin x = a;          y = b;          end
    p = x * y;
    return p[31:0];
  endfunction

  function automatic int ref_pad(input logic [15:0] b, input logic sgn);
    int   n;
    logic prev;
    n = 0;
`ifdef FX68K_MUL_TIMING_EN
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sgn) begin
        if (b[i] != prev) n++;
      end else if (b[i]) n++;
      prev = b[i];
    end
`else
    prev = sgn;
    if (prev) n = 0;
`endif
    return n;
  endfunction

  // period-1 clocks with en low, then one clock with en high; sample 1 time unit after the edge
  task automatic en_tick(input int period);
    for (int k = 1; k < period; k++) begin
      en = 1'b0;
      @(posedge clk); #1;
    end
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                        input int period, input int restart_at, input logic start_at_done);
    logic [31:0] exp;
    logic [3:0]  exp_ccr;
    int          cnt;
    exp     = ref_mul(a, b, sgn);
    exp_ccr = {exp[31], (exp == 32'd0), 2'b00};
    mcand = a; mplier = b; isSigned = sgn; start = 1'b1;
    en_tick(period);
    start = 1'b0;
    cnt   = 1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    mcand = 16'($urandom); mplier = 16'($urandom); isSigned = ~sgn;
    while (done !== 1'b1 && cnt < 100) begin
      check("prod_held", product, last_prod);
      if (cnt == restart_at) start = 1'b1;
      en_tick(period);
      start = 1'b0;
      cnt++;
    end
    check("latency", cnt, 17 + ref_pad(b, sgn));
    check("product", product, exp);
    check("ccr", {28'd0, ccrOut}, {28'd0, exp_ccr});
    check("busy_at_done", {31'd0, busy}, 32'd0);
    last_prod = exp;
    last_ccr  = exp_ccr;
    start = start_at_done;
    en_tick(period);
    start = 1'b0;
    check("done_cleared", {31'd0, done}, 32'd0);
    check("start_at_done_ignored", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          seen_done;
    logic [15:0] ra, rb;
    nReset = 1'b0; en = 1'b0; start = 1'b0; isSigned = 1'b0; abort = 1'b0;
    mcand = '0; mplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_ccr", {28'd0, ccrOut}, 32'd0);
    nReset = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h5678, 1'b0, 1, -1, 1'b0);
    check("mulu_1234_5678", product, 32'h06260060);
    run_op(16'hFFFF, 16'h0002, 1'b1, 1, -1, 1'b0);
    check("muls_ffff_2", product, 32'hFFFFFFFE);
    run_op(16'hFFFF, 16'h0002, 1'b0, 1, -1, 1'b1);
    check("mulu_ffff_2", product, 32'h0001FFFE);
    run_op(16'h0000, 16'hABCD, 1'b0, 2, -1, 1'b0);
    check("mulu_zero_ccr", {28'd0, ccrOut}, 32'h4);
    run_op(16'h8000, 16'h8000, 1'b1, 1, -1, 1'b0);
    check("muls_8000_8000", product, 32'h40000000);

    // sparse en with a second start mid-RUN
    run_op(16'hBEEF, 16'h1357, 1'b1, 4, 6, 1'b0);

    // abort after 8 en strobes; outputs keep previous result
    mcand = 16'h7777; mplier = 16'h3333; isSigned = 1'b0; start = 1'b1;
    en_tick(4);
    start = 1'b0;
    repeat (7) en_tick(4);
    abort = 1'b1;
    en_tick(4);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", product, last_prod);
    check("abort_ccr", {28'd0, ccrOut}, {28'd0, last_ccr});
    start = 1'b1; abort = 1'b1;
    en_tick(1);
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", {31'd0, busy}, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 24; k++) begin
      en_tick(1);
      if (done === 1'b1) seen_done++;
    end
    check("no_done_after_abort", seen_done, 0);

    // async reset in the middle of RUN
    mcand = 16'h4321; mplier = 16'h8765; isSigned = 1'b1; start = 1'b1;
    en_tick(1);
    start = 1'b0;
    repeat (5) en_tick(1);
    #2 nReset = 1'b0;
    #1;
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_product", product, 32'd0);
    check("midrun_rst_ccr", {28'd0, ccrOut}, 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;
    last_prod = '0;
    last_ccr  = '0;
    @(posedge clk); #1;

`ifdef FX68K_MUL_TIMING_EN
    run_op(16'h0003, 16'hFFFF, 1'b0, 1, -1, 1'b0);
    run_op(16'h0003, 16'h0000, 1'b0, 1, -1, 1'b0);
    run_op(16'h0005, 16'h5555, 1'b1, 1, -1, 1'b0);
    run_op(16'h0005, 16'h0000, 1'b1, 1, -1, 1'b0);
`endif

    for (int t = 0; t < 24; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (t % 6 == 0) ra = 16'h8000;
      if (t % 8 == 1) rb = 16'hFFFF;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(1, 3)), -1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
